i2s_tx: RTL and testbench
=========================

// Module: i2s_tx
// PURPOSE
//  I2S transmitter (DAC side): mirror of the I2S capture path. Free-running bus master;
//  derives ws from sck (sck = 64*fs, 32 sck per channel slot) and shifts a stereo pair
//  out on sd, MSB first, one sck after each ws edge. Upstream supplies left/right words
//  over a valid/ready handshake, one pair per frame; the loopback target is the capture block.
// PARAMETERS
//  DATA_W   24   bits sent per channel, taken from word bits [31:32-DATA_W]; legal 1..31
// PORTS
//  sck        in   1   bit clock; all logic on posedge sck
//  rst_n      in   1   asynchronous, active-low reset
//  start      in   1   level; leaves IDLE when sampled high
//  in_valid   in   1   stereo pair on in_left/in_right is valid
//  in_left    in   32  left word, MSB-justified (bit 31 first on the wire)
//  in_right   in   32  right word, MSB-justified
//  in_ready   out  1   combinational; 1 when state==RUN && cnt==63
//  ws         out  1   word select, registered; 0 = left slot, 1 = right slot
//  sd         out  1   serial data, registered
//  underrun   out  1   sticky; set when a frame starts without an accepted pair
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, cnt=63, ws=1, sd=0, underrun=0, shreg=0,
//   right_hold=0, left_hold=0. Outputs take these values immediately, mid-frame included.
//  States: IDLE -> RUN when start=1 at a posedge; RUN is left only by reset.
//   start is ignored while in RUN. In IDLE: ws=1, sd=0, cnt held at 63, in_ready=0.
//  cnt: 6-bit frame counter, increments every sck in RUN, wraps 63->0.
//   ws <= next cnt[5]; slot index k = next cnt[4:0].
//  Handshake: transfer = in_valid && in_ready (only in the cnt==63 cycle).
//   On transfer: left_hold<=in_left, right_hold<=in_right. No transfer in a cycle where
//   cnt!=63; in_valid/in_left/in_right ignored outside it. Exactly one pair per 64 sck.
//   No transfer at cnt==63: underrun<=1; cleared only by reset.
//  Frame-start edge (cnt 63->0): shreg<=pair left word (just-transferred value if a
//   transfer occurred that cycle, else held left, or 0 per CONFIGURATION); ws<=0; sd<=0.
//  Right-slot edge (cnt 31->32): shreg<=right word (same selection); ws<=1; sd<=0.
//  Slot timing per channel (k = slot index after the edge):
//   k=0          sd=0 (I2S one-bit delay slot)
//   k=1..DATA_W  sd=shreg[31]; shreg<<=1 (sends bits 31 down to 32-DATA_W)
//   k>DATA_W     sd=0
//  Timing ref: sd and ws change only on posedge; a receiver sampling on posedge sees MSB
//   on the 2nd edge after it first samples ws=0, which matches the capture block.
//  Latency: pair accepted at cnt==63 -> left MSB on sd 2 sck later; right MSB 34 sck later.
//  Simultaneous: start and in_valid in the same IDLE cycle: no transfer (in_ready=0);
//   first RUN cycle has cnt==63, so in_ready=1 there. If in_valid=0 there, underrun
//   sets immediately and the first frame sends reset-value (zero) words.
//  Reset deassertion: synchronised externally; block acts on first posedge with rst_n=1.
// CONFIGURATION
//  I2S_TX_ZERO_ON_UNDERRUN_EN
//   undefined: on underrun, left_hold/right_hold keep their values; previous pair repeats.
//   defined:   on underrun, both channels send all-zero words for that frame, and
//              left_hold/right_hold are cleared to 0. underrun sticky flag is identical in both builds.
// TESTING
//  1 rst_n=0 then 1 -> ws=1, sd=0, in_ready=0, underrun=0; stays so with start=0 for 200 sck.
//  2 start=1; in_valid=1 L=32'hABCDEF00 R=32'h12345600 -> in_ready 1 cycle, ws falls next
//    edge; sd slots 1..24 = 0xABCDEF MSB first, slots 25..31=0; capture block in loopback
//    outputs data 32'hABCDEF00 (left). Right slot carries 0x123456.
//  3 in_valid=0 at the 2nd cnt==63 -> underrun=1; default build repeats 0xABCDEF/0x123456;
//    I2S_TX_ZERO_ON_UNDERRUN_EN build sends zeros on both channels.
//  4 in_valid held 1 with a new pair each transfer for 8 frames -> in_ready high exactly
//    1 of every 64 sck; 8 pairs appear in order; underrun stays 0.
//  5 rst_n=0 at left slot k=10 -> ws=1, sd=0 same instant; start=0 after release keeps IDLE;
//    start=1 restarts with cnt sequence 63,0,1...
//  6 DATA_W=16, L=32'hFFFF_FFFF -> sd=1 on slots 1..16, 0 on slots 0 and 17..31.

Source files
------------

// File: rtl/i2s_tx_if.sv
// Stereo sample handshake between an upstream sample source and the I2S transmitter.
// Combinational only: the wires that carry one left/right pair.
// Backpressure: in_ready from the transmitter; a pair moves when in_valid && in_ready.
//
// Signals:
//   in_valid  source -> tx   stereo pair on in_left/in_right is valid
//   in_ready  tx -> source   transmitter takes a pair this cycle
//   in_left   source -> tx   32-bit left word, MSB-justified
//   in_right  source -> tx   32-bit right word, MSB-justified
interface i2s_tx_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_left;
    logic [31:0] in_right;

    modport master (
        output in_valid,
        output in_left,
        output in_right,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_left,
        input  in_right,
        output in_ready
    );
endinterface

// File: rtl/i2s_tx.sv
// I2S transmitter: free-running bus master on sck (64 sck per frame), shifts a stereo pair out MSB first.
// Latency: pair taken at cnt==63 -> left MSB on sd 2 sck later, right MSB 34 sck later.
// Backpressure: in_ready is high for one sck per frame; no pair at that point sets sticky underrun.
//
// Ports:
//   sck       bit clock, all state on its rising edge
//   rst_n     asynchronous active-low reset
//   start     level; moves IDLE -> RUN when sampled high, ignored afterwards
//   in_bus    i2s_tx_if slave: in_valid/in_left/in_right in, in_ready out (combinational)
//   ws        word select, registered (0 = left slot, 1 = right slot)
//   sd        serial data, registered
//   underrun  sticky, set when a frame starts without an accepted pair
//
// Build option: define I2S_TX_ZERO_ON_UNDERRUN_EN to send all-zero words for an underrun
// frame (and clear the held pair); otherwise the previous pair is repeated.
module i2s_tx #(
    parameter int DATA_W = 24   // bits sent per channel, taken from word bits [31:32-DATA_W]; 1..31
) (
    input  logic    sck,
    input  logic    rst_n,
    input  logic    start,
    i2s_tx_if.slave in_bus,
    output logic    ws,
    output logic    sd,
    output logic    underrun
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [5:0] DW = 6'(DATA_W);

    state_t      state;
    logic [5:0]  cnt;          // position in the 64-sck frame; 63 is the last sck of a frame
    logic [31:0] shreg;        // word being shifted out, current bit always at [31]
    logic [31:0] left_hold;
    logic [31:0] right_hold;

    logic        frame_end;    // last sck of the frame: the only cycle a pair may be taken
    logic        xfer;
    logic [5:0]  cnt_nx;
    logic [4:0]  slot_nx;      // bit index within the slot that starts after this edge
    logic [31:0] left_sel;     // pair the next edges load into shreg
    logic [31:0] right_sel;

    assign frame_end       = (state == RUN) && (cnt == 6'd63);
    assign in_bus.in_ready = frame_end;
    assign xfer            = frame_end && in_bus.in_valid;
    assign cnt_nx          = cnt + 6'd1;
    assign slot_nx         = cnt_nx[4:0];

    // A pair taken this very cycle goes straight into shreg at the frame-start edge,
    // so the held registers are bypassed here rather than read a cycle later.
    always_comb begin
        left_sel  = left_hold;
        right_sel = right_hold;
        if (xfer) begin
            left_sel  = in_bus.in_left;
            right_sel = in_bus.in_right;
        end
`ifdef I2S_TX_ZERO_ON_UNDERRUN_EN
        else if (frame_end) begin
            left_sel  = '0;
            right_sel = '0;
        end
`endif
    end

    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 6'd63;
            ws         <= 1'b1;
            sd         <= 1'b0;
            underrun   <= 1'b0;
            shreg      <= '0;
            left_hold  <= '0;
            right_hold <= '0;
        end else if (state == IDLE) begin
            // Parked at cnt==63 so the first RUN cycle is a frame end and offers in_ready.
            cnt <= 6'd63;
            ws  <= 1'b1;
            sd  <= 1'b0;
            if (start) begin
                state <= RUN;
            end
        end else begin
            cnt <= cnt_nx;
            ws  <= cnt_nx[5];

            if (frame_end) begin
                // In the default build left_sel/right_sel equal the held pair when nothing
                // arrived, so this keeps it; the zero build clears it.
                left_hold  <= left_sel;
                right_hold <= right_sel;
                if (!in_bus.in_valid) begin
                    underrun <= 1'b1;
                end
            end

            if (slot_nx == 5'd0) begin
                // Slot start: the I2S one-bit delay, so sd idles low while the word loads.
                shreg <= cnt_nx[5] ? right_sel : left_sel;
                sd    <= 1'b0;
            end else if ({1'b0, slot_nx} <= DW) begin
                sd    <= shreg[31];
                shreg <= {shreg[30:0], 1'b0};
            end else begin
                sd    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
module tb_i2s_tx;

    logic        sck      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_left  = '0;
    logic [31:0] in_right = '0;

    logic ws24, sd24, ur24;
    logic ws16, sd16, ur16;

    i2s_tx_if bus24 ();
    i2s_tx_if bus16 ();

    assign bus24.in_valid = in_valid;
    assign bus24.in_left  = in_left;
    assign bus24.in_right = in_right;
    assign bus16.in_valid = in_valid;
    assign bus16.in_left  = in_left;
    assign bus16.in_right = in_right;

    i2s_tx #(.DATA_W(24)) dut24 (
        .sck(sck), .rst_n(rst_n), .start(start), .in_bus(bus24),
        .ws(ws24), .sd(sd24), .underrun(ur24)
    );

    i2s_tx #(.DATA_W(16)) dut16 (
        .sck(sck), .rst_n(rst_n), .start(start), .in_bus(bus16),
        .ws(ws16), .sd(sd16), .underrun(ur16)
    );

    always #5 sck = ~sck;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

`ifdef I2S_TX_ZERO_ON_UNDERRUN_EN
    localparam bit ZERO_BUILD = 1'b1;
`else
    localparam bit ZERO_BUILD = 1'b0;
`endif

    // ---------------- frame-level model ----------------
    // Position p (0..63) of the sck after each edge; the pair of the current frame.
    bit          m_run;
    int          m_pos;
    bit          m_uf;
    logic [31:0] m_hold_l, m_hold_r, m_cur_l, m_cur_r;

    always @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_pos = 63; m_uf = 0;
            m_hold_l = '0; m_hold_r = '0; m_cur_l = '0; m_cur_r = '0;
        end else if (!m_run) begin
            if (start) m_run = 1;
        end else begin
            if (m_pos == 63) begin
                if (in_valid) begin
                    m_hold_l = in_left;
                    m_hold_r = in_right;
                end else begin
                    m_uf = 1;
                    if (ZERO_BUILD) begin
                        m_hold_l = '0;
                        m_hold_r = '0;
                    end
                end
                m_cur_l = m_hold_l;
                m_cur_r = m_hold_r;
            end
            m_pos = (m_pos + 1) % 64;
        end
    end

    // Bit expected on sd at frame position p for a channel width of dw.
    function automatic logic exp_sd(input int p, input logic [31:0] l, input logic [31:0] r, input int dw);
        int k;
        logic [31:0] w;
        k = p % 32;
        w = (p < 32) ? l : r;
        if (k >= 1 && k <= dw) return w[32-k];
        return 1'b0;
    endfunction

    bit chk_en = 0;

    always @(negedge sck) begin
        if (chk_en) begin
            logic e_ws, e_rdy;
            e_ws  = (m_pos >= 32);
            e_rdy = m_run && (m_pos == 63);
            check("ws24",       32'(ws24),           32'(e_ws));
            check("ws16",       32'(ws16),           32'(e_ws));
            check("sd24",       32'(sd24),           32'(exp_sd(m_pos, m_cur_l, m_cur_r, 24)));
            check("sd16",       32'(sd16),           32'(exp_sd(m_pos, m_cur_l, m_cur_r, 16)));
            check("in_ready24", 32'(bus24.in_ready), 32'(e_rdy));
            check("in_ready16", 32'(bus16.in_ready), 32'(e_rdy));
            check("underrun24", 32'(ur24),           32'(m_uf));
            check("underrun16", 32'(ur16),           32'(m_uf));
        end
    end

    // ---------------- independent I2S receiver ----------------
    // Samples like the capture block; words are stored MSB-justified.
    int          bi;
    logic        pws;
    logic [31:0] w24, w16;
    logic [31:0] rxl24[$], rxr24[$], rxl16[$], rxr16[$];

    always @(negedge sck or negedge rst_n) begin
        if (!rst_n) begin
            bi  = 99;
            pws = 1'b1;
        end else begin
            if (ws24 != pws) begin
                bi = 0; w24 = '0; w16 = '0;
            end else if (bi < 99) begin
                bi++;
            end
            if (bi >= 1 && bi <= 24) w24[32-bi] = sd24;
            if (bi >= 1 && bi <= 16) w16[32-bi] = sd16;
            if (bi == 24) begin
                if (ws24) rxr24.push_back(w24); else rxl24.push_back(w24);
            end
            if (bi == 16) begin
                if (ws24) rxr16.push_back(w16); else rxl16.push_back(w16);
            end
            pws = ws24;
        end
    end

    bit rdy_en  = 0;
    int rdy_cnt = 0;
    always @(negedge sck) if (rdy_en && bus24.in_ready) rdy_cnt++;

    task automatic send_pair(input logic [31:0] l, input logic [31:0] r, input string nm);
        bit got;
        got      = 0;
        in_left  = l;
        in_right = r;
        in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge sck);
            if (bus24.in_ready) begin
                got = 1;
                break;
            end
        end
        if (got) begin
            @(posedge sck);
            #1;
        end
        check({nm, " handshake"}, 32'(got), 32'd1);
    endtask

    task automatic wait_rx(input int nr);
        for (int n = 0; n < 400 && rxr24.size() < nr; n++) @(negedge sck);
        check("rx right word count", 32'(rxr24.size() >= nr), 32'd1);
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (q.size() > i) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    logic [31:0] tl[8];
    logic [31:0] tr[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        tl = '{32'h11223300, 32'h44556600, 32'h778899AA, 32'h00000100,
               32'h80000000, 32'h0F0F0F0F, 32'h5A5A5A5A, 32'hFFFFFFFF};
        tr = '{32'hAABBCC00, 32'hDDEEFF00, 32'h13579BDF, 32'h800000FF,
               32'h00000001, 32'hF0F0F0F0, 32'hA5A5A5A5, 32'hFFFFFFFF};

        // 1: reset and idle
        repeat (3) @(posedge sck);
        #1 rst_n = 1'b1;
        chk_en = 1;
        @(negedge sck);
        check("reset ws",       32'(ws24),           32'd1);
        check("reset sd",       32'(sd24),           32'd0);
        check("reset in_ready", 32'(bus24.in_ready), 32'd0);
        check("reset underrun", 32'(ur24),           32'd0);
        repeat (200) @(posedge sck);
        #1;
        check("idle ws",       32'(ws24),           32'd1);
        check("idle in_ready", 32'(bus24.in_ready), 32'd0);

        // 2: start together with the first pair
        start = 1'b1;
        send_pair(32'hABCDEF00, 32'h12345600, "first pair");
        start    = 1'b0;
        in_valid = 1'b0;
        wait_rx(1);
        check("left24 frame0",  qget(rxl24, 0), 32'hABCDEF00);
        check("right24 frame0", qget(rxr24, 0), 32'h12345600);
        check("left16 frame0",  qget(rxl16, 0), 32'hABCD0000);
        check("right16 frame0", qget(rxr16, 0), 32'h12340000);

        // 3: no pair at the next frame end
        wait_rx(2);
        check("underrun set", 32'(ur24), 32'd1);
        check("left24 underrun frame",  qget(rxl24, 1), ZERO_BUILD ? 32'h0 : 32'hABCDEF00);
        check("right24 underrun frame", qget(rxr24, 1), ZERO_BUILD ? 32'h0 : 32'h12345600);
        check("left16 underrun frame",  qget(rxl16, 1), ZERO_BUILD ? 32'h0 : 32'hABCD0000);

        // 5: reset in the middle of the left slot (k=10)
        hit = 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge sck);
            #1;
            if (m_run && m_pos == 10) begin
                hit = 1;
                break;
            end
        end
        check("reach slot k=10", 32'(hit), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid-frame reset ws",       32'(ws24),           32'd1);
        check("mid-frame reset sd",       32'(sd24),           32'd0);
        check("mid-frame reset in_ready", 32'(bus24.in_ready), 32'd0);
        check("mid-frame reset underrun", 32'(ur24),           32'd0);
        repeat (2) @(posedge sck);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge sck);
        #1;
        check("idle after reset ws",       32'(ws24),           32'd1);
        check("idle after reset in_ready", 32'(bus24.in_ready), 32'd0);
        rxl24.delete(); rxr24.delete(); rxl16.delete(); rxr16.delete();

        // 4 + 6: eight back-to-back pairs with in_valid held high
        rdy_cnt  = 0;
        rdy_en   = 1;
        start    = 1'b1;
        in_left  = tl[0];
        in_right = tr[0];
        in_valid = 1'b1;
        @(negedge sck);
        check("in_ready while start sampled", 32'(bus24.in_ready), 32'd0);
        @(negedge sck);
        check("in_ready first run cycle", 32'(bus24.in_ready), 32'd1);
        @(posedge sck);
        #1 start = 1'b0;
        @(negedge sck);
        check("ws falls after first transfer", 32'(ws24), 32'd0);
        for (int i = 1; i < 8; i++) send_pair(tl[i], tr[i], "stream pair");
        in_valid = 1'b0;
        wait_rx(8);
        rdy_en = 0;
        check("in_ready pulses", 32'(rdy_cnt), 32'd8);
        check("no underrun while streaming", 32'(ur24), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check("stream left24",  qget(rxl24, i), tl[i] & 32'hFFFFFF00);
            check("stream right24", qget(rxr24, i), tr[i] & 32'hFFFFFF00);
            check("stream left16",  qget(rxl16, i), tl[i] & 32'hFFFF0000);
            check("stream right16", qget(rxr16, i), tr[i] & 32'hFFFF0000);
        end
        check("all-ones left16",  qget(rxl16, 7), 32'hFFFF0000);
        check("all-ones left24",  qget(rxl24, 7), 32'hFFFFFF00);
        check("truncated left24", qget(rxl24, 2), 32'h77889900);

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
